// File: rtl/ptmch_pkg.sv
// ptmch trigger scheduler shared definitions.
// Register map, CTRL bit positions and FSM state type.
package ptmch_pkg;

  localparam int CNT_W_DEF = 24;

  localparam logic [3:0] A_CTRL   = 4'd0;
  localparam logic [3:0] A_PERIOD = 4'd1;
  localparam logic [3:0] A_COUNT  = 4'd2;
  localparam logic [3:0] A_CH_EN  = 4'd3;
  localparam logic [3:0] A_DLY0   = 4'd4;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;

  typedef enum logic {IDLE, RUN} sched_state_t;

endpackage

// File: rtl/ptmch_trg_chan.sv
// One trigger channel: window compare on the period
// counter and the registered TRG_PLS output flop.
module ptmch_trg_chan #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] pcnt,
  input  logic             run,
  input  logic             en,
  input  logic [CNT_W-1:0] dly,
  input  logic [CNT_W-1:0] wid,
  output logic             pls
);

  logic [CNT_W:0] lim;
  logic           hit;

  assign lim = {1'b0, dly} + {1'b0, wid};
  assign hit = en && (wid != '0) && (dly <= pcnt)
            && ({1'b0, pcnt} < lim);

  // pulse follows the compare one cycle later, forced low outside RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pls <= 1'b0;
    else        pls <= run & hit;
  end

endmodule

// File: rtl/ptmch_trg_sched.sv
// ptmch trigger-pulse scheduler: shadow/active config,
// period counter, burst counter and IDLE/RUN control.
module ptmch_trg_sched import ptmch_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int N_CH  = 2
) (
  input  logic            CLK160M,
  input  logic            RESET_N,
  input  logic            REG_WE,
  input  logic [3:0]      REG_ADDR,
  input  logic [31:0]     REG_WDATA,
  input  logic            EXT_TRG,
  output logic [N_CH-1:0] TRG_PLS,
  output logic            BUSY,
  output logic            DONE
);

  sched_state_t state, state_n;

  logic [CNT_W-1:0] sh_per, sh_cnt, sh_per_n, sh_cnt_n;
  logic [N_CH-1:0]  sh_en, sh_en_n;
  logic [CNT_W-1:0] sh_dly [N_CH];
  logic [CNT_W-1:0] sh_wid [N_CH];
  logic [CNT_W-1:0] sh_dly_n [N_CH];
  logic [CNT_W-1:0] sh_wid_n [N_CH];

  logic [CNT_W-1:0] ac_per, ac_cnt;
  logic [N_CH-1:0]  ac_en;
  logic [CNT_W-1:0] ac_dly [N_CH];
  logic [CNT_W-1:0] ac_wid [N_CH];

  logic [CNT_W-1:0] pcnt, rem, per_eff;
  logic             ctrl_we, stop, start_sw;
  logic             accept, wrap, done_n, done_q;
  logic             wdata_unused;

  assign wdata_unused = ^REG_WDATA[31:CNT_W];

  assign ctrl_we  = REG_WE && (REG_ADDR == A_CTRL);
  assign stop     = ctrl_we && REG_WDATA[CTRL_STOP];
  assign start_sw = ctrl_we && REG_WDATA[CTRL_START];

  assign per_eff = (ac_per == '0) ? CNT_W'(1) : ac_per;
  assign wrap    = (state == RUN)
                && (pcnt == per_eff - CNT_W'(1));

  assign BUSY = (state == RUN);
  assign DONE = done_q;

  // shadow register file with this cycle's write folded in
  always_comb begin
    sh_per_n = sh_per;
    sh_cnt_n = sh_cnt;
    sh_en_n  = sh_en;
    sh_dly_n = sh_dly;
    sh_wid_n = sh_wid;
    if (REG_WE) begin
      case (REG_ADDR)
        A_PERIOD: sh_per_n = REG_WDATA[CNT_W-1:0];
        A_COUNT:  sh_cnt_n = REG_WDATA[CNT_W-1:0];
        A_CH_EN:  sh_en_n  = REG_WDATA[N_CH-1:0];
        default:  ;
      endcase
      for (int i = 0; i < N_CH; i++) begin
        if (REG_ADDR == A_DLY0 + 4'(2*i))
          sh_dly_n[i] = REG_WDATA[CNT_W-1:0];
        if (REG_ADDR == A_DLY0 + 4'(2*i+1))
          sh_wid_n[i] = REG_WDATA[CNT_W-1:0];
      end
    end
  end

  // shadow registers
  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      sh_per <= CNT_W'(1);
      sh_cnt <= CNT_W'(1);
      sh_en  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        sh_dly[i] <= '0;
        sh_wid[i] <= '0;
      end
    end else begin
      sh_per <= sh_per_n;
      sh_cnt <= sh_cnt_n;
      sh_en  <= sh_en_n;
      sh_dly <= sh_dly_n;
      sh_wid <= sh_wid_n;
    end
  end

  // state register
  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= done_n;
    end
  end

  // start/stop/burst-end decisions; STOP beats any start
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!stop && (start_sw || EXT_TRG)) begin
          state_n = RUN;
          accept  = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
        end else if (wrap && (ac_cnt != '0)
                     && (rem == CNT_W'(1))) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
    endcase
  end

  // period counter, burst counter and active-set reload
  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      pcnt   <= '0;
      rem    <= '0;
      ac_per <= CNT_W'(1);
      ac_cnt <= CNT_W'(1);
      ac_en  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        ac_dly[i] <= '0;
        ac_wid[i] <= '0;
      end
    end else if (accept || wrap) begin
      pcnt   <= '0;
      ac_per <= sh_per_n;
      ac_cnt <= sh_cnt_n;
      ac_en  <= sh_en_n;
      ac_dly <= sh_dly_n;
      ac_wid <= sh_wid_n;
      if (accept)
        rem <= sh_cnt_n;
      else if (ac_cnt != '0)
        rem <= rem - CNT_W'(1);
    end else if (state == RUN) begin
      pcnt <= pcnt + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    ptmch_trg_chan #(.CNT_W(CNT_W)) u_chan (
      .clk   (CLK160M),
      .rst_n (RESET_N),
      .pcnt  (pcnt),
      .run   (BUSY),
      .en    (ac_en[g]),
      .dly   (ac_dly[g]),
      .wid   (ac_wid[g]),
      .pls   (TRG_PLS[g])
    );
  end

endmodule

// File: tb/tb_ptmch_trg_sched.sv
// Scoreboard bench for ptmch_trg_sched: a cycle-level
// reference model feeds expectations, a monitor compares.
module tb_ptmch_trg_sched;

  localparam int N_CH = 2;

  logic            CLK160M = 1'b0;
  logic            RESET_N = 1'b0;
  logic            REG_WE = 1'b0;
  logic [3:0]      REG_ADDR = 4'd0;
  logic [31:0]     REG_WDATA = 32'd0;
  logic            EXT_TRG = 1'b0;
  logic [N_CH-1:0] TRG_PLS;
  logic            BUSY;
  logic            DONE;

  int checks = 0;
  int errors = 0;

  ptmch_trg_sched #(.CNT_W(24), .N_CH(N_CH)) dut (
    .CLK160M   (CLK160M),
    .RESET_N   (RESET_N),
    .REG_WE    (REG_WE),
    .REG_ADDR  (REG_ADDR),
    .REG_WDATA (REG_WDATA),
    .EXT_TRG   (EXT_TRG),
    .TRG_PLS   (TRG_PLS),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 CLK160M = ~CLK160M;

  // reference model state: shadow config, active snapshot, burst
  int m_per, m_cnt, m_en;
  int m_dly [N_CH];
  int m_wid [N_CH];
  int a_per, a_cnt, a_en;
  int a_dly [N_CH];
  int a_wid [N_CH];
  bit m_run;
  int m_ph, m_left;
  int cyc_n = 0;

  logic [3:0] exp_q [$];
  logic [3:0] hist [int];

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic void m_snap();
    a_per = m_per;
    a_cnt = m_cnt;
    a_en  = m_en;
    a_dly = m_dly;
    a_wid = m_wid;
  endfunction

  function automatic void m_reset();
    m_per = 1;
    m_cnt = 1;
    m_en  = 0;
    for (int i = 0; i < N_CH; i++) begin
      m_dly[i] = 0;
      m_wid[i] = 0;
    end
    m_snap();
    m_run  = 0;
    m_ph   = 0;
    m_left = 0;
  endfunction

  // one clock of the model, evaluated with this cycle's inputs
  function automatic void model_step();
    bit st, sp, dn;
    int v, idx, pe;
    logic [N_CH-1:0] t;
    st = 0;
    sp = 0;
    dn = 0;
    v = int'(REG_WDATA & 32'h00FF_FFFF);
    if (REG_WE) begin
      if (REG_ADDR == 4'd0) begin
        st = REG_WDATA[0];
        sp = REG_WDATA[1];
      end else if (REG_ADDR == 4'd1) m_per = v;
      else if (REG_ADDR == 4'd2) m_cnt = v;
      else if (REG_ADDR == 4'd3) m_en = int'(REG_WDATA[1:0]);
      else if (int'(REG_ADDR) < 4 + 2*N_CH) begin
        idx = (int'(REG_ADDR) - 4) / 2;
        if (REG_ADDR[0] == 1'b0) m_dly[idx] = v;
        else                     m_wid[idx] = v;
      end
    end
    for (int i = 0; i < N_CH; i++)
      t[i] = m_run && ((a_en >> i) & 1) == 1 && a_wid[i] != 0
          && a_dly[i] <= m_ph
          && longint'(m_ph) < longint'(a_dly[i]) + longint'(a_wid[i]);
    if (!m_run) begin
      if (!sp && (st || EXT_TRG)) begin
        m_run  = 1;
        m_ph   = 0;
        m_left = m_cnt;
        m_snap();
      end
    end else if (sp) begin
      m_run = 0;
    end else begin
      pe = (a_per == 0) ? 1 : a_per;
      if (m_ph == pe - 1) begin
        m_ph = 0;
        if (a_cnt != 0) begin
          if (m_left == 1) begin
            m_run = 0;
            dn = 1;
          end else begin
            m_left--;
          end
        end
        m_snap();
      end else begin
        m_ph++;
      end
    end
    cyc_n++;
    exp_q.push_back({dn, m_run, t});
  endfunction

  // monitor: log and score every cycle's outputs
  always @(negedge CLK160M) begin
    logic [3:0] o;
    if (RESET_N) begin
      o = {DONE, BUSY, TRG_PLS};
      hist[cyc_n] = o;
      if (exp_q.size() != 0) chk("cycle", o, exp_q.pop_front());
    end
  end

  task automatic cyc(input logic we, input logic [3:0] a,
                     input logic [31:0] d, input logic ext);
    REG_WE = we;
    REG_ADDR = a;
    REG_WDATA = d;
    EXT_TRG = ext;
    @(posedge CLK160M);
    model_step();
    #1;
    REG_WE = 1'b0;
    REG_ADDR = 4'd0;
    REG_WDATA = 32'd0;
    EXT_TRG = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cyc(1'b1, a, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  initial begin
    int t0, s, nd, r;
    logic we, ext;
    logic [3:0] a;
    logic [31:0] d;
    m_reset();
    repeat (3) @(posedge CLK160M);
    @(negedge CLK160M);
    chk("reset_state", {DONE, BUSY, TRG_PLS}, 4'b0000);
    @(posedge CLK160M);
    #1 RESET_N = 1'b1;

    // counted burst, two channels
    wr(1, 10); wr(2, 3); wr(3, 3);
    wr(4, 2); wr(5, 3); wr(6, 5); wr(7, 1);
    t0 = cyc_n;
    wr(0, 1);
    idle(36);
    for (int k = 1; k <= 33; k++) begin
      bit b0, b1;
      b0 = (k >= 4 && k <= 6) || (k >= 14 && k <= 16)
        || (k >= 24 && k <= 26);
      b1 = (k == 7) || (k == 17) || (k == 27);
      chk($sformatf("burst_k%0d", k), hist[t0+k],
          {k == 31, k <= 30, b1, b0});
    end

    // continuous run from EXT_TRG, then STOP
    wr(2, 0); wr(1, 4); wr(4, 1); wr(5, 2); wr(3, 1);
    t0 = cyc_n;
    cyc(1'b0, 4'd0, 32'd0, 1'b1);
    idle(110);
    s = cyc_n;
    wr(0, 2);
    idle(4);
    chk("stop_s2", hist[s+2], 4'b0000);
    nd = 0;
    for (int c = t0; c <= s + 4; c++) nd += int'(hist[c][3]);
    chk("stop_no_done", 4'(nd), 4'd0);

    // clipping, unreachable delay, zero period
    wr(1, 8); wr(2, 2); wr(3, 3);
    wr(4, 6); wr(5, 5); wr(6, 8); wr(7, 3);
    wr(0, 1);
    idle(20);
    wr(1, 0); wr(2, 4); wr(4, 0); wr(5, 1);
    wr(0, 1);
    idle(8);

    // width edit in the middle of a period
    wr(1, 10); wr(2, 2); wr(3, 1); wr(4, 0); wr(5, 2);
    wr(0, 1);
    idle(5);
    wr(5, 4);
    idle(20);

    // START+STOP together in IDLE
    wr(0, 3);
    idle(3);

    // EXT_TRG held while running
    wr(1, 5); wr(2, 2);
    for (int i = 0; i < 8; i++) cyc(1'b0, 4'd0, 32'd0, 1'b1);
    idle(12);

    // start accepted in the DONE cycle
    wr(3, 0); wr(1, 3); wr(2, 1);
    t0 = cyc_n;
    wr(0, 1);
    idle(3);
    wr(0, 1);
    idle(6);
    chk("b2b_done", hist[t0+4], 4'b1000);
    chk("b2b_busy", hist[t0+5], 4'b0100);

    // asynchronous reset in the middle of a pulse
    wr(1, 10); wr(2, 0); wr(3, 1); wr(4, 0); wr(5, 6);
    wr(0, 1);
    idle(3);
    @(negedge CLK160M);
    #1 RESET_N = 1'b0;
    #1 chk("async_rst", {DONE, BUSY, TRG_PLS}, 4'b0000);
    m_reset();
    exp_q.delete();
    repeat (2) @(posedge CLK160M);
    #1 RESET_N = 1'b1;
    t0 = cyc_n;
    wr(0, 1);
    idle(4);
    chk("dflt_busy", hist[t0+1], 4'b0100);
    chk("dflt_done", hist[t0+2], 4'b1000);

    // randomized register traffic and external starts
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      we = 1'b0;
      a = 4'd0;
      d = 32'd0;
      if (r < 6) begin
        we = 1'b1;
        d = $urandom();
      end else if (r < 20) begin
        we = 1'b1;
        a = 4'($urandom_range(1, 15));
        d = ($urandom() & 32'hFF00_0000)
          | 32'($urandom_range(0, 12));
      end
      ext = ($urandom_range(0, 29) == 0);
      cyc(we, a, d, ext);
    end
    idle(2);
    @(negedge CLK160M);
    #1 chk("drain", 4'(exp_q.size()), 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
